// File: rtl/ram_clear_ctrl.sv
// Power-up clear sequencer: waits INIT_DELAY cycles, then zero-fills SDRAM and DDR3 concurrently.
// Define RAM_CLEAR_DDR_EN to build the DDR3 channel; otherwise it is tied off and reports finished.
module ram_clear_ctrl #(
  parameter int INIT_DELAY = 5000000,
  parameter int SDR_AW     = 25,
  parameter int DDR_WORDS  = 1 << 26,
  parameter int DDR_BURST  = 128,
  parameter int AUTO_START = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic              sdr_we,
  output logic [SDR_AW-1:0] sdr_addr,
  input  logic              sdr_ready,
  output logic              ddr_we,
  output logic [28:0]       ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  input  logic              ddr_busy,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | post-reset, waiting for start (or auto start)
  // DELAY | counting down INIT_DELAY cycles
  // CLEAR | both channels writing zeros
  // DONE  | all memory cleared, waiting for a re-run request
  typedef enum logic [1:0] {IDLE, DELAY, CLEAR, DONE} state_t;

  localparam logic [31:0]       DLY_LOAD = (INIT_DELAY > 0) ? 32'(INIT_DELAY - 1) : 32'd0;
  localparam logic [SDR_AW-1:0] SDR_LAST = '1;

  state_t      state;
  logic [31:0] dly_cnt;
  logic        launch;
  logic        enter_clear;
  logic        sdr_fin;
  logic        ddr_fin;

  // IDLE is only ever occupied right after reset, so auto start needs no extra flag
  assign launch = ((state == IDLE) && ((AUTO_START != 0) || start)) ||
                  ((state == DONE) && start);

  assign enter_clear = ((state == DELAY) && (dly_cnt == '0)) ||
                       (launch && (INIT_DELAY == 0));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      dly_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            busy <= 1'b1;
            done <= 1'b0;
            if (INIT_DELAY == 0) begin
              state <= CLEAR;
            end else begin
              state   <= DELAY;
              dly_cnt <= DLY_LOAD;
            end
          end
        end
        DELAY: begin
          if (dly_cnt == '0) begin
            state <= CLEAR;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end
        CLEAR: begin
          if (sdr_fin && ddr_fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // SDRAM: one word per accepted request; the address parks on the last word
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sdr_we   <= 1'b0;
      sdr_addr <= '0;
      sdr_fin  <= 1'b0;
    end else if (enter_clear) begin
      sdr_we   <= 1'b1;
      sdr_addr <= '0;
      sdr_fin  <= 1'b0;
    end else if (sdr_we && sdr_ready) begin
      if (sdr_addr == SDR_LAST) begin
        sdr_we  <= 1'b0;
        sdr_fin <= 1'b1;
      end else begin
        sdr_addr <= sdr_addr + SDR_AW'(1);
      end
    end
  end

`ifdef RAM_CLEAR_DDR_EN
  localparam logic [7:0]  BEAT_LOAD  = 8'(DDR_BURST - 1);
  localparam logic [7:0]  BURST_LEN  = 8'(DDR_BURST);
  localparam logic [28:0] BURST_STEP = 29'(DDR_BURST);
  localparam logic [31:0] BURST_LOAD = 32'(DDR_WORDS / DDR_BURST - 1);

  logic [7:0]  beat_cnt;
  logic [31:0] burst_left;
  logic        ddr_gap;

  // ddr_gap marks the single idle cycle between bursts
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ddr_we       <= 1'b0;
      ddr_addr     <= '0;
      ddr_burstcnt <= '0;
      beat_cnt     <= '0;
      burst_left   <= '0;
      ddr_gap      <= 1'b0;
      ddr_fin      <= 1'b0;
    end else if (enter_clear) begin
      ddr_we       <= 1'b1;
      ddr_addr     <= '0;
      ddr_burstcnt <= BURST_LEN;
      beat_cnt     <= BEAT_LOAD;
      burst_left   <= BURST_LOAD;
      ddr_gap      <= 1'b0;
      ddr_fin      <= 1'b0;
    end else if (ddr_we && !ddr_busy) begin
      if (beat_cnt == 8'd0) begin
        ddr_we       <= 1'b0;
        ddr_burstcnt <= '0;
        ddr_addr     <= ddr_addr + BURST_STEP;
        if (burst_left == '0) begin
          ddr_fin <= 1'b1;
        end else begin
          burst_left <= burst_left - 32'd1;
          ddr_gap    <= 1'b1;
        end
      end else begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end else if (ddr_gap) begin
      ddr_gap      <= 1'b0;
      ddr_we       <= 1'b1;
      ddr_burstcnt <= BURST_LEN;
      beat_cnt     <= BEAT_LOAD;
    end
  end
`else
  logic        unused_ddr_busy;
  logic [31:0] unused_ddr_cfg;

  assign unused_ddr_busy = ddr_busy;
  assign unused_ddr_cfg  = 32'(DDR_WORDS) ^ 32'(DDR_BURST);
  assign ddr_we          = 1'b0;
  assign ddr_addr        = '0;
  assign ddr_burstcnt    = '0;
  assign ddr_fin         = 1'b1;
`endif

endmodule
